// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the SLC-3.2 memory responder.
// Holds the responder FSM encoding, the default I/O word address and the read lane mask.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR
    } mem_state_t;

    localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;

    // Deasserted (high) lane strobes zero that byte of the returned word.
    function automatic logic [15:0] lane_mask(input logic [15:0] word,
                                              input logic        ub_n,
                                              input logic        lb_n);
        lane_mask = {ub_n ? 8'h00 : word[15:8], lb_n ? 8'h00 : word[7:0]};
    endfunction

endpackage

// File: rtl/mem_responder_mem_array.sv
// Word RAM with combinational read and per-byte synchronous write enables.
// Contents are deliberately not reset.
module mem_array #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              Clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       wdata,
    input  logic [1:0]        byte_we,
    output logic [15:0]       rdata
);

    logic [15:0] mem [2**ADDR_W];

    always_ff @(posedge Clk) begin
        if (byte_we[1]) mem[addr][15:8] <= wdata[15:8];
        if (byte_we[0]) mem[addr][7:0]  <= wdata[7:0];
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: answers the active-low SRAM strobe protocol with a
// byte-laned word RAM plus one memory-mapped I/O word (switches / hex display).
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_W  = 10,
    parameter logic [15:0] IO_ADDR = IO_ADDR_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] ADDR,
    input  logic [15:0] Data_in,
    input  logic        Mem_CE,
    input  logic        Mem_UB,
    input  logic        Mem_LB,
    input  logic        Mem_OE,
    input  logic        Mem_WE,
    input  logic [15:0] Switches,
    output logic [15:0] Data_out,
    output logic [15:0] HEX_reg,
    output logic        Busy,
    output logic        Conflict
);

    mem_state_t  state;
    logic        wr_req;
    logic        rd_req;
    logic        io_sel;
    logic        wr_commit;
    logic [1:0]  ram_byte_we;
    logic [15:0] ram_rdata;
    logic [15:0] rd_word;

    assign wr_req    = ~Mem_CE & ~Mem_WE;
    assign rd_req    = ~Mem_CE & ~Mem_OE & Mem_WE;
    assign io_sel    = (ADDR == IO_ADDR);
    // The single commit happens only on the IDLE->WR edge; Reset blocks it so
    // a reset held across an edge can never produce a stray write.
    assign wr_commit = (state == IDLE) && wr_req && !Reset;

    assign ram_byte_we = {2{wr_commit & ~io_sel}} & {~Mem_UB, ~Mem_LB};
    assign rd_word     = io_sel ? Switches : ram_rdata;

    mem_array #(
        .ADDR_W(ADDR_W)
    ) u_mem_array (
        .Clk     (Clk),
        .addr    (ADDR[ADDR_W-1:0]),
        .wdata   (Data_in),
        .byte_we (ram_byte_we),
        .rdata   (ram_rdata)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            Data_out <= '0;
            HEX_reg  <= '0;
            Busy     <= 1'b0;
            Conflict <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_req) begin
                        state <= WR;
                        Busy  <= 1'b1;
                        if (!Mem_OE) Conflict <= 1'b1;
                        if (io_sel) begin
                            if (!Mem_UB) HEX_reg[15:8] <= Data_in[15:8];
                            if (!Mem_LB) HEX_reg[7:0]  <= Data_in[7:0];
                        end
                    end else if (rd_req) begin
                        state    <= RD;
                        Busy     <= 1'b1;
                        Data_out <= lane_mask(rd_word, Mem_UB, Mem_LB);
                    end
                end
                RD: begin
                    if (Mem_CE || Mem_OE) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end
                end
                WR: begin
                    if (!wr_req) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder: per-feature tasks with
// hand-computed expectations, inputs driven and outputs sampled on the falling edge.
module tb_mem_responder;

    logic        Clk;
    logic        Reset;
    logic [15:0] ADDR;
    logic [15:0] Data_in;
    logic        Mem_CE;
    logic        Mem_UB;
    logic        Mem_LB;
    logic        Mem_OE;
    logic        Mem_WE;
    logic [15:0] Switches;
    logic [15:0] Data_out;
    logic [15:0] HEX_reg;
    logic        Busy;
    logic        Conflict;

    int checks = 0;
    int errors = 0;

    mem_responder #(
        .ADDR_W  (10),
        .IO_ADDR (16'hFFFF)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .ADDR     (ADDR),
        .Data_in  (Data_in),
        .Mem_CE   (Mem_CE),
        .Mem_UB   (Mem_UB),
        .Mem_LB   (Mem_LB),
        .Mem_OE   (Mem_OE),
        .Mem_WE   (Mem_WE),
        .Switches (Switches),
        .Data_out (Data_out),
        .HEX_reg  (HEX_reg),
        .Busy     (Busy),
        .Conflict (Conflict)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic idle_bus();
        Mem_CE = 1'b1;
        Mem_OE = 1'b1;
        Mem_WE = 1'b1;
        Mem_UB = 1'b0;
        Mem_LB = 1'b0;
    endtask

    // Two-cycle write; Data_in is inverted in the second cycle so any second commit shows up.
    task automatic do_write(input logic [15:0] a, input logic [15:0] d,
                            input logic ub, input logic lb);
        @(negedge Clk);
        ADDR = a; Data_in = d; Mem_UB = ub; Mem_LB = lb;
        Mem_CE = 1'b0; Mem_WE = 1'b0; Mem_OE = 1'b1;
        @(negedge Clk);
        Data_in = ~d;
        @(negedge Clk);
        idle_bus();
        @(negedge Clk);
    endtask

    // Two-cycle read; ADDR is disturbed in the second cycle, which must not matter.
    task automatic do_read(input logic [15:0] a, input logic ub, input logic lb,
                           output logic [15:0] rd1, output logic [15:0] rd2);
        @(negedge Clk);
        ADDR = a; Mem_UB = ub; Mem_LB = lb;
        Mem_CE = 1'b0; Mem_OE = 1'b0; Mem_WE = 1'b1;
        @(negedge Clk);
        rd1 = Data_out;
        ADDR = a ^ 16'h0001;
        @(negedge Clk);
        rd2 = Data_out;
        idle_bus();
        @(negedge Clk);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        idle_bus();
        ADDR = '0; Data_in = '0; Switches = '0;
        repeat (2) @(negedge Clk);
        checks++; if (Data_out !== 16'h0000) begin errors++; $display("FAIL reset_data_out: got %h expected 0000", Data_out); end
        checks++; if (HEX_reg !== 16'h0000) begin errors++; $display("FAIL reset_hex: got %h expected 0000", HEX_reg); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", Busy); end
        checks++; if (Conflict !== 1'b0) begin errors++; $display("FAIL reset_conflict: got %b expected 0", Conflict); end
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_write_read();
        logic [15:0] r1, r2;
        @(negedge Clk);
        ADDR = 16'h0010; Data_in = 16'hBEEF; Mem_UB = 1'b0; Mem_LB = 1'b0;
        Mem_CE = 1'b0; Mem_WE = 1'b0;
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL busy_before_edge: got %b expected 0", Busy); end
        @(negedge Clk);
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL busy_in_write: got %b expected 1", Busy); end
        Data_in = 16'hDEAD;
        @(negedge Clk);
        idle_bus();
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL busy_second_write_cycle: got %b expected 1", Busy); end
        @(negedge Clk);
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL busy_fall: got %b expected 0", Busy); end
        do_read(16'h0010, 1'b0, 1'b0, r1, r2);
        checks++; if (r1 !== 16'hBEEF) begin errors++; $display("FAIL read_first_cycle: got %h expected beef", r1); end
        checks++; if (r2 !== 16'hBEEF) begin errors++; $display("FAIL read_second_cycle: got %h expected beef", r2); end
        checks++; if (Data_out !== 16'hBEEF) begin errors++; $display("FAIL read_hold_after_strobe: got %h expected beef", Data_out); end
    endtask

    task automatic test_byte_lanes();
        logic [15:0] r1, r2;
        do_write(16'h0005, 16'h1234, 1'b0, 1'b0);
        do_write(16'h0005, 16'hABCD, 1'b1, 1'b0);
        do_read(16'h0005, 1'b0, 1'b0, r1, r2);
        checks++; if (r2 !== 16'h12CD) begin errors++; $display("FAIL lane_write_low: got %h expected 12cd", r2); end
        do_read(16'h0005, 1'b0, 1'b1, r1, r2);
        checks++; if (r2 !== 16'h1200) begin errors++; $display("FAIL lane_read_lb_off: got %h expected 1200", r2); end
        do_read(16'h0005, 1'b1, 1'b0, r1, r2);
        checks++; if (r2 !== 16'h00CD) begin errors++; $display("FAIL lane_read_ub_off: got %h expected 00cd", r2); end
    endtask

    task automatic test_io();
        logic [15:0] r1, r2;
        do_write(16'h03FF, 16'h5555, 1'b0, 1'b0);
        Switches = 16'h00A5;
        do_read(16'hFFFF, 1'b0, 1'b0, r1, r2);
        checks++; if (r2 !== 16'h00A5) begin errors++; $display("FAIL io_read_switches: got %h expected 00a5", r2); end
        do_write(16'hFFFF, 16'h0F0F, 1'b0, 1'b0);
        checks++; if (HEX_reg !== 16'h0F0F) begin errors++; $display("FAIL io_write_hex: got %h expected 0f0f", HEX_reg); end
        do_read(16'h03FF, 1'b0, 1'b0, r1, r2);
        checks++; if (r2 !== 16'h5555) begin errors++; $display("FAIL io_write_ram_untouched: got %h expected 5555", r2); end
        do_write(16'hFFFF, 16'h3C3C, 1'b0, 1'b1);
        checks++; if (HEX_reg !== 16'h3C0F) begin errors++; $display("FAIL io_write_hex_upper_lane: got %h expected 3c0f", HEX_reg); end
    endtask

    task automatic test_ce_alias();
        logic [15:0] r1, r2;
        do_write(16'h0020, 16'h1111, 1'b0, 1'b0);
        @(negedge Clk);
        ADDR = 16'h0020; Data_in = 16'h2222; Mem_CE = 1'b1; Mem_WE = 1'b0;
        @(negedge Clk);
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL ce_gate_busy: got %b expected 0", Busy); end
        @(negedge Clk);
        idle_bus();
        do_read(16'h0020, 1'b0, 1'b0, r1, r2);
        checks++; if (r2 !== 16'h1111) begin errors++; $display("FAIL ce_gate_no_write: got %h expected 1111", r2); end
        do_write(16'h0400, 16'h4444, 1'b0, 1'b0);
        do_read(16'h0000, 1'b0, 1'b0, r1, r2);
        checks++; if (r2 !== 16'h4444) begin errors++; $display("FAIL alias_read: got %h expected 4444", r2); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] r1, r2;
        do_write(16'h0051, 16'h0000, 1'b0, 1'b0);
        @(negedge Clk);
        ADDR = 16'h0050; Data_in = 16'h5050; Mem_CE = 1'b0; Mem_WE = 1'b0;
        @(negedge Clk);
        ADDR = 16'h0051; Data_in = 16'h5151;
        repeat (2) @(negedge Clk);
        idle_bus();
        @(negedge Clk);
        do_read(16'h0050, 1'b0, 1'b0, r1, r2);
        checks++; if (r1 !== 16'h5050) begin errors++; $display("FAIL b2b_first_addr: got %h expected 5050", r1); end
        do_read(16'h0051, 1'b0, 1'b0, r1, r2);
        checks++; if (r1 !== 16'h0000) begin errors++; $display("FAIL b2b_held_strobe_no_write: got %h expected 0000", r1); end
    endtask

    task automatic test_conflict();
        logic [15:0] r1, r2;
        checks++; if (Conflict !== 1'b0) begin errors++; $display("FAIL conflict_initial: got %b expected 0", Conflict); end
        @(negedge Clk);
        ADDR = 16'h0003; Data_in = 16'h7777; Mem_UB = 1'b0; Mem_LB = 1'b0;
        Mem_CE = 1'b0; Mem_OE = 1'b0; Mem_WE = 1'b0;
        @(negedge Clk);
        checks++; if (Conflict !== 1'b1) begin errors++; $display("FAIL conflict_set: got %b expected 1", Conflict); end
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL conflict_busy: got %b expected 1", Busy); end
        idle_bus();
        repeat (2) @(negedge Clk);
        do_read(16'h0003, 1'b0, 1'b0, r1, r2);
        checks++; if (r2 !== 16'h7777) begin errors++; $display("FAIL conflict_write_done: got %h expected 7777", r2); end
        checks++; if (Conflict !== 1'b1) begin errors++; $display("FAIL conflict_sticky: got %b expected 1", Conflict); end
    endtask

    task automatic test_reset_mid_read();
        logic [15:0] r1, r2;
        @(negedge Clk);
        ADDR = 16'h0010; Mem_UB = 1'b0; Mem_LB = 1'b0;
        Mem_CE = 1'b0; Mem_OE = 1'b0; Mem_WE = 1'b1;
        @(negedge Clk);
        checks++; if (Data_out !== 16'hBEEF) begin errors++; $display("FAIL mid_read_loaded: got %h expected beef", Data_out); end
        Reset = 1'b1;
        #1;
        checks++; if (Data_out !== 16'h0000) begin errors++; $display("FAIL mid_read_reset_data: got %h expected 0000", Data_out); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL mid_read_reset_busy: got %b expected 0", Busy); end
        checks++; if (Conflict !== 1'b0) begin errors++; $display("FAIL reset_clears_conflict: got %b expected 0", Conflict); end
        @(negedge Clk);
        idle_bus();
        Reset = 1'b0;
        @(negedge Clk);
        do_read(16'h0010, 1'b0, 1'b0, r1, r2);
        checks++; if (r2 !== 16'hBEEF) begin errors++; $display("FAIL read_after_reset: got %h expected beef", r2); end
    endtask

    task automatic test_reset_mid_write();
        logic [15:0] r1, r2;
        @(negedge Clk);
        ADDR = 16'h0030; Data_in = 16'h3333; Mem_UB = 1'b0; Mem_LB = 1'b0;
        Mem_CE = 1'b0; Mem_WE = 1'b0; Mem_OE = 1'b1;
        @(negedge Clk);
        Reset = 1'b1;
        Data_in = 16'h9999;
        #1;
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL mid_write_reset_busy: got %b expected 0", Busy); end
        @(negedge Clk);
        idle_bus();
        Reset = 1'b0;
        @(negedge Clk);
        do_read(16'h0030, 1'b0, 1'b0, r1, r2);
        checks++; if (r2 !== 16'h3333) begin errors++; $display("FAIL mid_write_committed_once: got %h expected 3333", r2); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_io();
        test_ce_alias();
        test_back_to_back();
        test_conflict();
        test_reset_mid_read();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
